// File: rtl/y86_pkg.sv
// Shared Y86 constants: register IDs, the "no register" ID and default widths.
package y86_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_AW     = 4;

  localparam logic [DEF_AW-1:0] RNONE = 4'hF;

  localparam logic [DEF_AW-1:0] EAX = 4'h0;
  localparam logic [DEF_AW-1:0] ECX = 4'h1;
  localparam logic [DEF_AW-1:0] EDX = 4'h2;
  localparam logic [DEF_AW-1:0] EBX = 4'h3;
  localparam logic [DEF_AW-1:0] ESP = 4'h4;
  localparam logic [DEF_AW-1:0] EBP = 4'h5;
  localparam logic [DEF_AW-1:0] ESI = 4'h6;
  localparam logic [DEF_AW-1:0] EDI = 4'h7;

endpackage

// File: rtl/y86_sb_counter.sv
// Saturating pending-write counter: +inc minus up to two retires per cycle;
// ovf/unf flag the cycle in which saturation clamps the result.
module y86_sb_counter #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic [1:0]       dec,
  output logic [CNT_W-1:0] count,
  output logic             ovf,
  output logic             unf
);

  logic [1:0]     nDec;
  logic [CNT_W:0] up;
  logic [CNT_W:0] nxt;

  // One extra bit catches the +1 overflow; underflow is detected before subtracting.
  always_comb begin
    nDec = {1'b0, dec[0]} + {1'b0, dec[1]};
    up   = {1'b0, count} + {{CNT_W{1'b0}}, inc};
    unf  = up < (CNT_W+1)'(nDec);
    nxt  = up - (CNT_W+1)'(nDec);
    ovf  = !unf && nxt[CNT_W];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (unf) begin
      count <= '0;
    end else if (!ovf) begin
      count <= nxt[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/y86_regfile_mp.sv
// Multi-port Y86 register file with pending-write scoreboard.
// Optional write-to-read bypass: define REGFILE_BYPASS_EN.
module y86_regfile_mp
  import y86_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned NREG   = 8,
  parameter int unsigned AW     = DEF_AW,
  parameter int unsigned NRD    = 2,
  parameter int unsigned CNT_W  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NRD*AW-1:0]     rd_src,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  wr_m_en,
  input  logic [AW-1:0]         wr_m_dst,
  input  logic [DATA_W-1:0]     wr_m_val,
  input  logic                  wr_e_en,
  input  logic [AW-1:0]         wr_e_dst,
  input  logic [DATA_W-1:0]     wr_e_val,
  input  logic                  iss_en,
  input  logic [AW-1:0]         iss_dst,
  output logic                  sb_err
);

  localparam int unsigned   IW      = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [AW-1:0] NREG_ID = AW'(NREG);

  logic [DATA_W-1:0] regs [NREG];
  logic [CNT_W-1:0]  cnt  [NREG];
  logic [NREG-1:0]   ovf;
  logic [NREG-1:0]   unf;
  logic              wrMAcc;
  logic              wrEAcc;
  logic              issAcc;

  assign wrMAcc = wr_m_en && (wr_m_dst < NREG_ID);
  assign wrEAcc = wr_e_en && (wr_e_dst < NREG_ID);
  assign issAcc = iss_en  && (iss_dst  < NREG_ID);

  // E is applied after M so it wins a same-register collision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned r = 0; r < NREG; r++) regs[r] <= '0;
    end else begin
      if (wrMAcc) regs[wr_m_dst[IW-1:0]] <= wr_m_val;
      if (wrEAcc) regs[wr_e_dst[IW-1:0]] <= wr_e_val;
    end
  end

  for (genvar r = 0; r < NREG; r++) begin : g_sb
    logic       inc;
    logic [1:0] dec;
    assign inc = issAcc && (iss_dst == AW'(r));
    assign dec = {wrEAcc && (wr_e_dst == AW'(r)), wrMAcc && (wr_m_dst == AW'(r))};
    y86_sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk  (clk),
      .reset(reset),
      .inc  (inc),
      .dec  (dec),
      .count(cnt[r]),
      .ovf  (ovf[r]),
      .unf  (unf[r])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sb_err <= 1'b0;
    end else if (|{ovf, unf}) begin
      sb_err <= 1'b1;
    end
  end

  logic [AW-1:0] src;
`ifdef REGFILE_BYPASS_EN
  logic [1:0]    nRet;
  logic          drained;
`endif

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    src     = '0;
`ifdef REGFILE_BYPASS_EN
    nRet    = '0;
    drained = 1'b0;
`endif
    for (int unsigned i = 0; i < NRD; i++) begin
      src = rd_src[i*AW +: AW];
      if (src < NREG_ID) begin
`ifdef REGFILE_BYPASS_EN
        if (wrEAcc && (wr_e_dst == src)) begin
          rd_data[i*DATA_W +: DATA_W] = wr_e_val;
        end else if (wrMAcc && (wr_m_dst == src)) begin
          rd_data[i*DATA_W +: DATA_W] = wr_m_val;
        end else begin
          rd_data[i*DATA_W +: DATA_W] = regs[src[IW-1:0]];
        end
        // Busy drops early only when this cycle's retires empty the counter with no new issue.
        nRet    = {1'b0, wrEAcc && (wr_e_dst == src)} + {1'b0, wrMAcc && (wr_m_dst == src)};
        drained = !(issAcc && (iss_dst == src)) &&
                  ((CNT_W+2)'(nRet) >= (CNT_W+2)'(cnt[src[IW-1:0]]));
        rd_busy[i] = (cnt[src[IW-1:0]] != '0) && !drained;
`else
        rd_data[i*DATA_W +: DATA_W] = regs[src[IW-1:0]];
        rd_busy[i] = (cnt[src[IW-1:0]] != '0);
`endif
      end
    end
  end

endmodule

// File: tb/tb_y86_regfile_mp.sv
// Scoreboard bench for y86_regfile_mp: directed scenarios then random traffic
// against an array-based reference model.
module tb_y86_regfile_mp;

  logic        clk;
  logic        reset;
  logic [7:0]  rdSrc;
  logic [63:0] rdData;
  logic [1:0]  rdBusy;
  logic        wrMEn, wrEEn, issEn;
  logic [3:0]  wrMDst, wrEDst, issDst;
  logic [31:0] wrMVal, wrEVal;
  logic        sbErr;

  y86_regfile_mp #(
    .DATA_W(32),
    .NREG  (8),
    .AW    (4),
    .NRD   (2),
    .CNT_W (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .rd_src  (rdSrc),
    .rd_data (rdData),
    .rd_busy (rdBusy),
    .wr_m_en (wrMEn),
    .wr_m_dst(wrMDst),
    .wr_m_val(wrMVal),
    .wr_e_en (wrEEn),
    .wr_e_dst(wrEDst),
    .wr_e_val(wrEVal),
    .iss_en  (issEn),
    .iss_dst (issDst),
    .sb_err  (sbErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  busy;
    logic        err;
    string       tag;
  } exp_t;

  exp_t        q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] mReg[8];
  int          mCnt[8];
  bit          mErr;

  task automatic rd(input int a, input int b);
    rdSrc = {4'(b), 4'(a)};
  endtask

  // Expected outputs come from the model state before this cycle's edge.
  task automatic tick(input string tag);
    exp_t       e;
    bit         mA, eA, iA;
    int         n, s;
    if (!reset) begin
      for (int k = 0; k < 8; k++) begin mReg[k] = '0; mCnt[k] = 0; end
      mErr = 0;
    end
    mA = reset && wrMEn && (wrMDst < 8);
    eA = reset && wrEEn && (wrEDst < 8);
    iA = reset && issEn && (issDst < 8);
    e.tag = tag; e.data = '0; e.busy = '0; e.err = mErr;
    for (int p = 0; p < 2; p++) begin
      s = int'(rdSrc[p*4 +: 4]);
      if (s < 8) begin
        e.data[p*32 +: 32] = mReg[s];
        e.busy[p] = (mCnt[s] != 0);
`ifdef REGFILE_BYPASS_EN
        if (eA && int'(wrEDst) == s) e.data[p*32 +: 32] = wrEVal;
        else if (mA && int'(wrMDst) == s) e.data[p*32 +: 32] = wrMVal;
        if (mCnt[s] + int'(iA && int'(issDst) == s) - int'(mA && int'(wrMDst) == s)
            - int'(eA && int'(wrEDst) == s) <= 0) e.busy[p] = 1'b0;
`endif
      end
    end
    q.push_back(e);
    if (reset) begin
      if (mA) mReg[int'(wrMDst)] = wrMVal;
      if (eA) mReg[int'(wrEDst)] = wrEVal;
      for (int k = 0; k < 8; k++) begin
        n = mCnt[k] + int'(iA && int'(issDst) == k) - int'(mA && int'(wrMDst) == k)
            - int'(eA && int'(wrEDst) == k);
        if (n > 3) begin n = 3; mErr = 1; end
        else if (n < 0) begin n = 0; mErr = 1; end
        mCnt[k] = n;
      end
    end
    @(posedge clk); #1;
    wrMEn = 1'b0; wrEEn = 1'b0; issEn = 1'b0;
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int p = 0; p < 2; p++) begin
          checks++;
          if (rdData[p*32 +: 32] !== e.data[p*32 +: 32]) begin
            failures++;
            $display("FAIL %s rd_data[%0d] got=%h exp=%h", e.tag, p, rdData[p*32 +: 32], e.data[p*32 +: 32]);
          end
        end
        checks++;
        if (rdBusy !== e.busy) begin
          failures++;
          $display("FAIL %s rd_busy got=%b exp=%b", e.tag, rdBusy, e.busy);
        end
        checks++;
        if (sbErr !== e.err) begin
          failures++;
          $display("FAIL %s sb_err got=%b exp=%b", e.tag, sbErr, e.err);
        end
      end
    end
  end

  initial begin
    reset = 1'b0; rdSrc = '0;
    wrMEn = 1'b0; wrEEn = 1'b0; issEn = 1'b0;
    wrMDst = '0; wrEDst = '0; issDst = '0; wrMVal = '0; wrEVal = '0;
    for (int k = 0; k < 8; k++) begin mReg[k] = '0; mCnt[k] = 0; end
    mErr = 0;
    repeat (2) @(posedge clk);
    #1;
    rd(0, 15); tick("rst_hold");
    reset = 1'b1;
    for (int k = 0; k < 8; k += 2) begin rd(k, k + 1); tick("rst_read"); end
    rd(15, 8); tick("rst_none");

    issEn = 1; issDst = 3; rd(3, 3); tick("iss3");
    wrEEn = 1; wrEDst = 3; wrEVal = 32'hDEAD_BEEF; rd(3, 3); tick("wr3_same");
    rd(3, 3); tick("wr3_next");

    issEn = 1; issDst = 2; tick("iss2a");
    issEn = 1; issDst = 2; tick("iss2b");
    wrMEn = 1; wrMDst = 2; wrMVal = 32'h1111;
    wrEEn = 1; wrEDst = 2; wrEVal = 32'h2222; rd(2, 2); tick("wr2_both");
    rd(2, 2); tick("wr2_next");

    for (int k = 0; k < 3; k++) begin issEn = 1; issDst = 5; rd(5, 5); tick("iss5"); end
    issEn = 1; issDst = 5; rd(5, 5); tick("iss5_ovf");
    rd(5, 5); tick("busy5");
    wrMEn = 1; wrMDst = 5; wrEEn = 1; wrEDst = 5; tick("ret5_two");
    wrEEn = 1; wrEDst = 5; rd(5, 5); tick("ret5_last");
    rd(5, 5); tick("idle5");

    reset = 1'b0; tick("rst_clr");
    reset = 1'b1;
    issEn = 1; issDst = 4; rd(4, 4); tick("iss4");
    issEn = 1; issDst = 4; wrEEn = 1; wrEDst = 4; wrEVal = 32'h44; tick("iss_ret4");
    rd(4, 4); tick("hold4");
    wrMEn = 1; wrMDst = 4; wrEEn = 1; wrEDst = 4; tick("dbl_ret4");
    rd(4, 4); tick("unf4");

    reset = 1'b0; tick("rst_b");
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin issEn = 1; issDst = 1; tick("iss1"); end
    wrEEn = 1; wrEDst = 1; wrEVal = 32'h5; tick("wr1");
    rd(1, 1); tick("pre_rst");
    reset = 1'b0; rd(1, 1); tick("mid_rst");
    reset = 1'b1;
    wrMEn = 1; wrMDst = 8; wrMVal = 32'hAAAA;
    wrEEn = 1; wrEDst = 15; wrEVal = 32'hBBBB; rd(8, 15); tick("bad_ids");
    for (int k = 0; k < 8; k += 2) begin rd(k, k + 1); tick("after_bad"); end

    for (int c = 0; c < 400; c++) begin
      reset  = ($urandom_range(0, 39) != 0);
      wrMEn  = ($urandom_range(0, 2) == 0);
      wrEEn  = ($urandom_range(0, 2) == 0);
      issEn  = ($urandom_range(0, 1) == 0);
      wrMDst = 4'($urandom_range(0, 9));
      wrEDst = 4'($urandom_range(0, 9));
      issDst = 4'($urandom_range(0, 8));
      if (wrMDst == 4'd9) wrMDst = 4'hF;
      wrMVal = $urandom;
      wrEVal = $urandom;
      rd($urandom_range(0, 15), $urandom_range(0, 8));
      if ($urandom_range(0, 3) == 0) rdSrc[7:4] = wrEDst;
      tick("random");
    end
    reset = 1'b1;

    for (int w = 0; w < 5 && q.size() > 0; w++) @(posedge clk);
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
